ooo_dispatch_scoreboard: RTL and testbench
==========================================

Name: ooo_dispatch_scoreboard

Overview:
- Parametrised successor to the out-of-order decode latch.
- Takes one decoded instruction per cycle over a valid/ready handshake and checks source operands against a tagged register scoreboard.
- Allocates a completion-buffer tag and dispatches into one of NUM_FU registered functional-unit channels, each with its own valid/ready handshake.
- Handles serializing instructions (fence/CSR), halt, and pipeline flush. Sits between decode and the functional-unit issue ports.

Parameters:
- NUM_FU, 4, number of functional-unit dispatch channels (>=2).
- NUM_REGS, 32, architectural registers; x0 is never busy.
- TAG_W, 3, completion-buffer tag width.
- PAYLOAD_W, 96, opaque per-instruction payload (ports, immediates, control) passed through unchanged.

Ports:
- CLK in 1: clock.
- RST in 1: asynchronous, active-high reset.
- flush in 1: pipeline flush (mispredict/exception).
- in_valid in 1: decoded instruction present.
- in_ready out 1: instruction accepted this cycle.
- in_fu_sel in NUM_FU: one-hot target channel.
- in_rs1, in_rs2, in_rd in $clog2(NUM_REGS): register indices.
- in_rs1_used, in_rs2_used, in_wen in 1: source-read and dest-write qualifiers.
- in_serialize in 1: instruction must issue with the machine drained.
- in_halt in 1: halt instruction.
- in_payload in PAYLOAD_W: pass-through payload.
- cb_alloc_ready in 1: completion buffer has a free entry.
- cb_alloc_tag in TAG_W: tag to be assigned.
- cb_alloc out 1: allocation strobe, equal to fire.
- cb_empty in 1: completion buffer holds no entries.
- wb_valid in 1: writeback strobe.
- wb_rd in $clog2(NUM_REGS): writeback destination register.
- wb_tag in TAG_W: writeback tag.
- out_valid out NUM_FU: per-channel dispatch valid.
- out_ready in NUM_FU: per-channel accept.
- out_tag out NUM_FU*TAG_W: per-channel tag, channel i at [i*TAG_W +: TAG_W].
- out_payload out NUM_FU*PAYLOAD_W: per-channel payload.
- halted out 1: halt instruction has been dispatched.

Behaviour:
- Reset (RST high, asynchronous):
  - busy[] = 0, tag[] = 0, out_valid = 0, out_tag = 0, out_payload = 0.
  - state = RUN, halted = 0.
- Scoreboard: per register, a busy bit plus a TAG_W tag.
- Operand ready: src_ok = (~in_rs1_used | in_rs1==0 | ~busy[rs1]) and the same for rs2.
- Channel ready: chan_ok = ~out_valid[i] | out_ready[i] for the selected i (pass-through while draining).
- drained = no busy bits & out_valid==0 & cb_empty.
- fire = in_valid & ~flush & src_ok & chan_ok & cb_alloc_ready & state_ok, where state_ok is:
  - RUN: ~in_serialize or drained;
  - DRAIN: drained;
  - HALT: 0.
- in_ready = fire. No combinational path from in_valid to in_ready other than through fire.
- On fire:
  - out_valid[i] <= 1; out_tag/out_payload[i] <= cb_alloc_tag/in_payload.
  - If in_wen & in_rd != 0: busy[rd] <= 1 and tag[rd] <= cb_alloc_tag.
- Channel handshake: out_valid[i] clears on out_ready[i] unless re-filled the same cycle. Data is held stable while valid and not ready.
- Writeback: wb_valid clears busy[wb_rd] only if tag[wb_rd] == wb_tag; a stale tag has no effect. If writeback and a dispatch set hit the same rd in the same cycle, the set wins.
- Dispatch latency: one cycle from fire to out_valid.
- FSM:
  - RUN -> DRAIN when in_valid & in_serialize & ~drained.
  - DRAIN -> RUN on fire.
  - any state -> HALT on fire with in_halt; halted = 1.
  - HALT holds until flush.
- Flush (highest priority, synchronous): busy[] = 0, out_valid = 0, state = RUN, halted = 0; no fire that cycle.
- WAW hazards are permitted: a newer tag overwrites an older one.
- Illegal input: in_fu_sel not one-hot is illegal; the RTL asserts this in simulation.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined: a same-cycle wb_valid whose tag matches the source register's current tag counts as not busy in src_ok, so a dependent instruction fires in the writeback cycle.
- Undefined: the dependent instruction fires no earlier than the cycle after writeback.

Test Plan (NUM_FU=4, TAG_W=3):
- Reset:
  - Stimulus: RST high, then low; in_valid=1, rd=5, wen, fu_sel=0001, cb_alloc_tag=2.
  - Response: next cycle out_valid=0001, out_tag[0]=2, busy[5]=1.
- RAW:
  - Stimulus: instruction B reads rs1=5 while busy[5] is set with tag 2.
  - Response: in_ready=0. After wb_valid, wb_rd=5, wb_tag=2, B fires the next cycle; with ISSUE_WB_BYPASS_EN it fires in the writeback cycle.
- Stale writeback:
  - Stimulus: tag[5] updated to 6 by a second writer; then wb_rd=5, wb_tag=2.
  - Response: busy[5] stays 1.
- Channel backpressure:
  - Stimulus: out_ready[1]=0 with out_valid[1]=1; new instruction targets channel 1.
  - Response: in_ready=0 and payload held. With out_ready[1]=1 in the same cycle, a back-to-back fire occurs.
- Serialize:
  - Stimulus: in_serialize while busy[3]=1.
  - Response: state=DRAIN, in_ready=0. After the writeback clears busy[3] with out_valid=0 and cb_empty=1, it fires and state returns to RUN.
- Halt/flush:
  - Stimulus: halt instruction dispatched.
  - Response: halted=1 and further in_valid is ignored. flush=1 then clears busy, out_valid, and halted in one cycle.

Source files
------------

// File: rtl/ooo_dispatch_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ooo_dispatch_scoreboard                                          |
// | Brief   : Decode-to-issue stage. Checks source operands against a tagged   |
// |           register scoreboard, allocates a completion-buffer tag and       |
// |           dispatches into one of NUM_FU registered FU channels. Handles    |
// |           serializing instructions, halt and pipeline flush.               |
// | Option  : ISSUE_WB_BYPASS_EN - a same-cycle writeback with a matching tag  |
// |           releases a dependent source operand in the writeback cycle.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ooo_dispatch_scoreboard #(
  parameter int NUM_FU    = 4,
  parameter int NUM_REGS  = 32,
  parameter int TAG_W     = 3,
  parameter int PAYLOAD_W = 96,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NUM_FU-1:0]             in_fu_sel_i,
  input  logic [REG_W-1:0]              in_rs1_i,
  input  logic [REG_W-1:0]              in_rs2_i,
  input  logic [REG_W-1:0]              in_rd_i,
  input  logic                          in_rs1_used_i,
  input  logic                          in_rs2_used_i,
  input  logic                          in_wen_i,
  input  logic                          in_serialize_i,
  input  logic                          in_halt_i,
  input  logic [PAYLOAD_W-1:0]          in_payload_i,
  input  logic                          cb_alloc_ready_i,
  input  logic [TAG_W-1:0]              cb_alloc_tag_i,
  output logic                          cb_alloc_o,
  input  logic                          cb_empty_i,
  input  logic                          wb_valid_i,
  input  logic [REG_W-1:0]              wb_rd_i,
  input  logic [TAG_W-1:0]              wb_tag_i,
  output logic [NUM_FU-1:0]             out_valid_o,
  input  logic [NUM_FU-1:0]             out_ready_i,
  output logic [NUM_FU*TAG_W-1:0]       out_tag_o,
  output logic [NUM_FU*PAYLOAD_W-1:0]   out_payload_o,
  output logic                          halted_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                            state_q, state_d;
  logic [NUM_REGS-1:0]               busy_q, busy_d;
  logic [NUM_REGS-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [NUM_FU-1:0]                 out_valid_q, out_valid_d;
  logic [NUM_FU-1:0][TAG_W-1:0]      out_tag_q, out_tag_d;
  logic [NUM_FU-1:0][PAYLOAD_W-1:0]  out_payload_q, out_payload_d;

  logic [NUM_REGS-1:0] busy_eff;
  logic                rs1_ok, rs2_ok, chan_ok, drained, state_ok, fire;

  // Busy view used for operand checks; optionally released by a matching writeback
  always_comb begin
    busy_eff = busy_q;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_valid_i && (tag_q[wb_rd_i] == wb_tag_i)) begin
      busy_eff[wb_rd_i] = 1'b0;
    end
`else
    busy_eff = busy_q;
`endif
  end

  assign rs1_ok  = !in_rs1_used_i || (in_rs1_i == '0) || !busy_eff[in_rs1_i];
  assign rs2_ok  = !in_rs2_used_i || (in_rs2_i == '0) || !busy_eff[in_rs2_i];
  // A full channel still accepts when it is being emptied this same cycle
  assign chan_ok = |(in_fu_sel_i & (~out_valid_q | out_ready_i));
  // Drained looks at registered busy bits only: a serializing op waits one
  // cycle past the last writeback even when the bypass is enabled
  assign drained = ~|busy_q && ~|out_valid_q && cb_empty_i;

  // Gate dispatch by machine state
  always_comb begin
    state_ok = 1'b0;
    case (state_q)
      ST_RUN:   state_ok = !in_serialize_i || drained;
      ST_DRAIN: state_ok = drained;
      default:  state_ok = 1'b0;
    endcase
  end

  assign fire = in_valid_i && !flush_i && rs1_ok && rs2_ok && chan_ok &&
                cb_alloc_ready_i && state_ok;

  assign in_ready_o = fire;
  assign cb_alloc_o = fire;
  assign halted_o   = (state_q == ST_HALT);

  // Next machine state: flush first, then halt, then drain bookkeeping
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else if (fire && in_halt_i) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_RUN:   if (in_valid_i && in_serialize_i && !drained) state_d = ST_DRAIN;
        ST_DRAIN: if (fire) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // Scoreboard update: matching writeback clears, a same-cycle dispatch set wins
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_valid_i && (tag_q[wb_rd_i] == wb_tag_i)) begin
        busy_d[wb_rd_i] = 1'b0;
      end
      if (fire && in_wen_i && (in_rd_i != '0)) begin
        busy_d[in_rd_i] = 1'b1;
        tag_d[in_rd_i]  = cb_alloc_tag_i;
      end
    end
  end

  // Per-channel output registers: refill on fire, empty on accept, hold otherwise
  always_comb begin
    out_valid_d   = out_valid_q;
    out_tag_d     = out_tag_q;
    out_payload_d = out_payload_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (flush_i) begin
        out_valid_d[i] = 1'b0;
      end else if (fire && in_fu_sel_i[i]) begin
        out_valid_d[i]   = 1'b1;
        out_tag_d[i]     = cb_alloc_tag_i;
        out_payload_d[i] = in_payload_i;
      end else if (out_ready_i[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  // State, scoreboard and channel registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      busy_q        <= '0;
      tag_q         <= '0;
      out_valid_q   <= '0;
      out_tag_q     <= '0;
      out_payload_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_tag_q     <= out_tag_d;
      out_payload_q <= out_payload_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_tag_o     = out_tag_q;
  assign out_payload_o = out_payload_q;

`ifndef SYNTHESIS
  // Channel select must be one-hot whenever an instruction is presented
  always_ff @(posedge clk_i) begin
    if (!rst_i && in_valid_i) begin
      assert ($onehot(in_fu_sel_i))
        else $error("in_fu_sel_i not one-hot: %b", in_fu_sel_i);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ooo_dispatch_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ooo_dispatch_scoreboard                                       |
// | Brief   : Directed scenarios plus randomized traffic against a behavioural |
// |           model of ooo_dispatch_scoreboard (NUM_FU=4, TAG_W=3).            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ooo_dispatch_scoreboard;

  localparam int NUM_FU    = 4;
  localparam int NUM_REGS  = 32;
  localparam int TAG_W     = 3;
  localparam int PAYLOAD_W = 96;
`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_fu_sel;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_used, in_rs2_used, in_wen, in_serialize, in_halt;
  logic [95:0] in_payload;
  logic        cb_alloc_ready, cb_alloc, cb_empty;
  logic [2:0]  cb_alloc_tag;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [2:0]  wb_tag;
  logic [3:0]  out_valid, out_ready;
  logic [11:0] out_tag;
  logic [383:0] out_payload;
  logic        halted;

  int errors = 0;
  int checks = 0;

  ooo_dispatch_scoreboard #(
    .NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_fu_sel_i(in_fu_sel),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
    .in_rs1_used_i(in_rs1_used), .in_rs2_used_i(in_rs2_used), .in_wen_i(in_wen),
    .in_serialize_i(in_serialize), .in_halt_i(in_halt), .in_payload_i(in_payload),
    .cb_alloc_ready_i(cb_alloc_ready), .cb_alloc_tag_i(cb_alloc_tag),
    .cb_alloc_o(cb_alloc), .cb_empty_i(cb_empty),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_tag_i(wb_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
    .out_payload_o(out_payload), .halted_o(halted)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_fu_sel = 4'b0001;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rs1_used = 1'b0; in_rs2_used = 1'b0; in_wen = 1'b0;
    in_serialize = 1'b0; in_halt = 1'b0; in_payload = '0;
    cb_alloc_ready = 1'b1; cb_alloc_tag = '0; cb_empty = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_tag = '0; out_ready = 4'b1111;
  endtask

  task automatic set_instr(input logic [3:0] sel, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rd, input logic wen, input logic ser,
                           input logic hlt, input logic [2:0] atag, input logic [95:0] pay);
    in_valid = 1'b1; in_fu_sel = sel; in_rs1 = rs1; in_rs1_used = u1;
    in_rs2 = '0; in_rs2_used = 1'b0; in_rd = rd; in_wen = wen;
    in_serialize = ser; in_halt = hlt; cb_alloc_tag = atag; in_payload = pay;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [95:0] pa;
    pa = 96'hA5A5_0001_DEAD_BEEF_0000_1111;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
    checks++; if (out_tag !== 12'b0) begin errors++; $display("FAIL reset_tag: got %h want 000", out_tag); end
    checks++; if (out_payload !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", out_payload); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    @(negedge clk);
    rst = 1'b0;
    set_instr(4'b0001, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd2, pa);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_fire: in_ready=%b want 1", in_ready); end
    checks++; if (cb_alloc !== 1'b1) begin errors++; $display("FAIL reset_cb_alloc: got %b want 1", cb_alloc); end
    @(negedge clk);
    idle_inputs();
    out_ready = 4'b0000;
    #1;
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL reset_dispatch_valid: got %b want 0001", out_valid); end
    checks++; if (out_tag[2:0] !== 3'd2) begin errors++; $display("FAIL reset_dispatch_tag: got %0d want 2", out_tag[2:0]); end
    checks++; if (out_payload[95:0] !== pa) begin errors++; $display("FAIL reset_dispatch_payload: got %h want %h", out_payload[95:0], pa); end
  endtask

  // Continues from test_reset: r5 busy with tag 2
  task automatic test_raw();
    logic [95:0] pb;
    pb = 96'h0BB0_1234_5678_9ABC_DEF0_0B0B;
    @(negedge clk);
    set_instr(4'b0010, 5'd5, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 3'd3, pb);
    out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_blocked: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_tag = 3'd2;
    #1;
    checks++; if (in_ready !== BYP) begin errors++; $display("FAIL raw_wb_cycle: in_ready=%b want %b", in_ready, BYP); end
    @(negedge clk);
    wb_valid = 1'b0;
    if (!BYP) begin
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb: in_ready=%b want 1", in_ready); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL raw_dispatch_valid: got %b want 0010", out_valid); end
    checks++; if (out_tag[5:3] !== 3'd3) begin errors++; $display("FAIL raw_dispatch_tag: got %0d want 3", out_tag[5:3]); end
    checks++; if (out_payload[191:96] !== pb) begin errors++; $display("FAIL raw_dispatch_payload: got %h want %h", out_payload[191:96], pb); end
  endtask

  task automatic test_stale_wb();
    do_reset();
    @(negedge clk);
    set_instr(4'b0001, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd2, 96'h1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stale_first_writer: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    set_instr(4'b0010, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd6, 96'h2);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stale_waw_writer: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_tag = 3'd2;
    #1;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL stale_out_valid: got %b want 0010", out_valid); end
    @(negedge clk);
    wb_valid = 1'b0;
    set_instr(4'b0100, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1, 96'h3);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stale_wb_ignored: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_tag = 3'd6;
    #1;
    checks++; if (in_ready !== BYP) begin errors++; $display("FAIL stale_match_wb_cycle: in_ready=%b want %b", in_ready, BYP); end
    @(negedge clk);
    wb_valid = 1'b0;
    if (!BYP) begin
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stale_after_match_wb: in_ready=%b want 1", in_ready); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [95:0] p1, p2;
    p1 = 96'h1111_2222_3333_4444_5555_6666;
    p2 = 96'h7777_8888_9999_AAAA_BBBB_CCCC;
    do_reset();
    @(negedge clk);
    out_ready = 4'b0000;
    set_instr(4'b0010, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1, p1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    set_instr(4'b0010, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd3, p2);
    #1;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid: got %b want 0010", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked: in_ready=%b want 0", in_ready); end
    @(negedge clk); #1;
    checks++; if (out_tag[5:3] !== 3'd1) begin errors++; $display("FAIL bp_tag_held: got %0d want 1", out_tag[5:3]); end
    checks++; if (out_payload[191:96] !== p1) begin errors++; $display("FAIL bp_payload_held: got %h want %h", out_payload[191:96], p1); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_blocked: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    out_ready = 4'b0010;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_back_to_back: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    idle_inputs();
    out_ready = 4'b0000;
    #1;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_refill_valid: got %b want 0010", out_valid); end
    checks++; if (out_tag[5:3] !== 3'd3) begin errors++; $display("FAIL bp_refill_tag: got %0d want 3", out_tag[5:3]); end
    checks++; if (out_payload[191:96] !== p2) begin errors++; $display("FAIL bp_refill_payload: got %h want %h", out_payload[191:96], p2); end
    @(negedge clk);
    out_ready = 4'b0010;
    @(negedge clk); #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drained: got %b want 0000", out_valid); end
  endtask

  task automatic test_serialize();
    do_reset();
    @(negedge clk);
    set_instr(4'b0001, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd4, 96'h10);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ser_producer: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    set_instr(4'b0010, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd5, 96'h11);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ser_stall: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    set_instr(4'b0100, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd5, 96'h12);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ser_drain_blocks_plain: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    set_instr(4'b0010, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd5, 96'h11);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_tag = 3'd4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ser_wb_cycle: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    wb_valid = 1'b0; cb_empty = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ser_cb_not_empty: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    cb_empty = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ser_fire: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    set_instr(4'b0001, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 3'd6, 96'h13);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ser_run_writer: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    set_instr(4'b0100, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd7, 96'h14);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ser_back_to_run: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_halt_flush();
    do_reset();
    @(negedge clk);
    out_ready = 4'b0000;
    set_instr(4'b0100, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 3'd5, 96'h20);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL halt_fire: in_ready=%b want 1", in_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_instr(4'b0001, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1, 96'h21);
      #1;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_ignores_input: in_ready=%b want 0", in_ready); end
    end
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL halt_out_valid: got %b want 0100", out_valid); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_no_fire: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    set_instr(4'b0001, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 3'd2, 96'h22);
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL flush_halted: got %b want 0", halted); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL flush_out_valid: got %b want 0000", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_cleared: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Randomized traffic against a behavioural model of the stage
  task automatic test_random();
    bit          m_busy[NUM_REGS];
    logic [2:0]  m_tag[NUM_REGS];
    bit          m_vld[NUM_FU];
    logic [2:0]  m_otag[NUM_FU];
    logic [95:0] m_opay[NUM_FU];
    int          m_state;  // 0 running, 1 waiting to drain, 2 halted
    logic [3:0]  ev;
    logic [11:0] et;
    logic [383:0] ep;
    bit          b1, b2, ok1, ok2, chok, drn, sok, efire, anybusy, anyvld, clr;
    int          ch;

    do_reset();
    for (int r = 0; r < NUM_REGS; r++) begin m_busy[r] = 0; m_tag[r] = '0; end
    for (int i = 0; i < NUM_FU; i++) begin m_vld[i] = 0; m_otag[i] = '0; m_opay[i] = '0; end
    m_state = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_FU; i++) begin
        ev[i] = m_vld[i];
        et[i*3 +: 3] = m_otag[i];
        ep[i*96 +: 96] = m_opay[i];
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL rnd_out_valid cyc %0d: got %b want %b", cyc, out_valid, ev); end
      checks++; if (out_tag !== et) begin errors++; $display("FAIL rnd_out_tag cyc %0d: got %h want %h", cyc, out_tag, et); end
      checks++; if (out_payload !== ep) begin errors++; $display("FAIL rnd_out_payload cyc %0d: got %h want %h", cyc, out_payload, ep); end
      checks++; if (halted !== (m_state == 2)) begin errors++; $display("FAIL rnd_halted cyc %0d: got %b want %b", cyc, halted, (m_state == 2)); end

      ch = $urandom_range(0, 3);
      in_fu_sel    = 4'b0001 << ch;
      in_valid     = ($urandom_range(0, 99) < 70);
      in_rs1       = 5'($urandom_range(0, 7));
      in_rs2       = 5'($urandom_range(0, 7));
      in_rd        = 5'($urandom_range(0, 7));
      in_rs1_used  = $urandom_range(0, 1);
      in_rs2_used  = $urandom_range(0, 1);
      in_wen       = ($urandom_range(0, 99) < 60);
      in_serialize = ($urandom_range(0, 99) < 8);
      in_halt      = ($urandom_range(0, 99) < 1);
      in_payload   = {$urandom, $urandom, $urandom};
      cb_alloc_ready = ($urandom_range(0, 99) < 85);
      cb_alloc_tag = 3'($urandom_range(0, 7));
      cb_empty     = $urandom_range(0, 1);
      wb_valid     = ($urandom_range(0, 99) < 40);
      wb_rd        = 5'($urandom_range(0, 7));
      wb_tag       = ($urandom_range(0, 99) < 70) ? m_tag[wb_rd] : 3'($urandom_range(0, 7));
      out_ready    = 4'($urandom_range(0, 15));
      flush        = ($urandom_range(0, 99) < 3);
      #1;

      b1 = m_busy[in_rs1];
      b2 = m_busy[in_rs2];
      if (BYP && wb_valid && wb_tag == m_tag[wb_rd]) begin
        if (wb_rd == in_rs1) b1 = 0;
        if (wb_rd == in_rs2) b2 = 0;
      end
      ok1 = !in_rs1_used || in_rs1 == 0 || !b1;
      ok2 = !in_rs2_used || in_rs2 == 0 || !b2;
      chok = !m_vld[ch] || out_ready[ch];
      anybusy = 0;
      for (int r = 0; r < NUM_REGS; r++) if (m_busy[r]) anybusy = 1;
      anyvld = 0;
      for (int i = 0; i < NUM_FU; i++) if (m_vld[i]) anyvld = 1;
      drn = !anybusy && !anyvld && cb_empty;
      sok = (m_state == 0) ? (!in_serialize || drn) : (m_state == 1) ? drn : 0;
      efire = in_valid && !flush && ok1 && ok2 && chok && cb_alloc_ready && sok;
      checks++; if (in_ready !== efire) begin errors++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, in_ready, efire); end
      checks++; if (cb_alloc !== efire) begin errors++; $display("FAIL rnd_cb_alloc cyc %0d: got %b want %b", cyc, cb_alloc, efire); end

      if (flush) begin
        for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
        for (int i = 0; i < NUM_FU; i++) m_vld[i] = 0;
        m_state = 0;
      end else begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (efire && i == ch) begin
            m_vld[i] = 1; m_otag[i] = cb_alloc_tag; m_opay[i] = in_payload;
          end else if (out_ready[i]) begin
            m_vld[i] = 0;
          end
        end
        clr = wb_valid && (m_tag[wb_rd] == wb_tag);
        if (clr) m_busy[wb_rd] = 0;
        if (efire && in_wen && in_rd != 0) begin
          m_busy[in_rd] = 1; m_tag[in_rd] = cb_alloc_tag;
        end
        if (efire && in_halt) m_state = 2;
        else if (m_state == 0 && in_valid && in_serialize && !drn) m_state = 1;
        else if (m_state == 1 && efire) m_state = 0;
      end
    end

    // Reset must take effect without waiting for a clock edge
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL async_reset_valid: got %b want 0000", out_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_reset_halted: got %b want 0", halted); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_raw();
    test_stale_wb();
    test_backpressure();
    test_serialize();
    test_halt_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
